alu_seq_core: RTL

Parametrised, handshaked successor to the combinational ALU core: accepts one operation per transfer on a valid/ready input port, returns a registered result plus flags on a valid/ready output port. Adds shifts, compares, carry/negative/illegal flags, a sticky overflow flag, and an optional iterative multiplier. Sits between the operand-issue logic and the writeback stage of the datapath.

---
 rtl/alu_pkg.sv | 35 +++
 rtl/alu_mul_iter.sv | 63 ++++++
 rtl/alu_seq_core.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared opcode constants, FSM state encoding and flag record for |
// |            alu_seq_core and its iterative multiplier.                      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_XOR  = 4'b0100;
  localparam logic [3:0] OP_SLT  = 4'b0101;
  localparam logic [3:0] OP_SLTU = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;

  localparam int         ST_W        = 1;
  localparam logic [0:0] ST_IDLE     = 1'b0;
  localparam logic [0:0] ST_MUL_BUSY = 1'b1;

  typedef struct packed {
    logic zero;
    logic negative;
    logic carry;
    logic overflow;
    logic illegal;
  } alu_flags_t;

endpackage
`default_nettype wire

// File: rtl/alu_mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_mul_iter                                                    |
// | Purpose  : Unsigned shift-add multiplier, one partial product per cycle,   |
// |            WIDTH iterations after i_start, full 2*WIDTH product.           |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic               o_busy,
  output logic               o_done,
  output logic [2*WIDTH-1:0] o_product
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [2*WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [2*WIDTH-1:0] r_prod;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_active;

  // Load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_mcand  <= {{WIDTH{1'b0}}, i_a};
      r_mplier <= i_b;
      r_prod   <= '0;
      r_cnt    <= CNT_W'(WIDTH);
      r_active <= 1'b1;
    end else if (r_active) begin
      if (r_cnt != '0) begin
        if (r_mplier[0]) begin
          r_prod <= r_prod + r_mcand;
        end
        r_mcand  <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt    <= r_cnt - 1'b1;
      end else begin
        // Product has been presented for one cycle as done; retire
        r_active <= 1'b0;
      end
    end
  end

  assign o_busy    = r_active && (r_cnt != '0);
  assign o_done    = r_active && (r_cnt == '0);
  assign o_product = r_prod;

endmodule
`default_nettype wire

// File: rtl/alu_seq_core.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_core                                                    |
// | Purpose  : Handshaked ALU: valid/ready in, registered result + flags out,  |
// |            sticky overflow, optional iterative multiplier.                 |
// | Config   : define ALU_MUL_EN to build the multiplier (opcode MUL);         |
// |            otherwise MUL is reported as an illegal opcode.                 |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module alu_seq_core
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             negative,
  output logic             carry,
  output logic             overflow,
  output logic             illegal,
  output logic             busy,
  output logic             ovf_sticky,
  input  logic             clr_sticky
);

  localparam int MSB = WIDTH - 1;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  alu_flags_t       r_flags;
  logic             r_ovf_sticky;

  logic             w_accept;
  logic             w_out_xfer;
  logic             w_is_mul;
  logic             w_in_busy;
  logic             w_mul_busy;
  logic             w_mul_done;
  logic [2*WIDTH-1:0] w_mul_prod;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_diff;
  logic [WIDTH-1:0] w_alu_res;
  logic             w_alu_c;
  logic             w_alu_v;
  logic             w_alu_ill;

  assign w_shamt = b[SHW-1:0];
  assign w_sum   = {1'b0, a} + {1'b0, b};
  assign w_diff  = a - b;

  // Single-cycle ALU datapath; anything not decoded here is illegal
  always_comb begin
    w_alu_res = '0;
    w_alu_c   = 1'b0;
    w_alu_v   = 1'b0;
    w_alu_ill = 1'b0;
    case (op)
      OP_ADD: begin
        w_alu_res = w_sum[MSB:0];
        w_alu_c   = w_sum[WIDTH];
        w_alu_v   = (a[MSB] == b[MSB]) && (w_sum[MSB] != a[MSB]);
      end
      OP_SUB: begin
        w_alu_res = w_diff;
        w_alu_c   = (a < b);
        w_alu_v   = (a[MSB] != b[MSB]) && (w_diff[MSB] != a[MSB]);
      end
      OP_AND:  w_alu_res = a & b;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SLT:  w_alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: w_alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
      OP_SLL:  w_alu_res = a << w_shamt;
      OP_SRL:  w_alu_res = a >> w_shamt;
      OP_SRA:  w_alu_res = $signed(a) >>> w_shamt;
      default: w_alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_MUL_EN
  logic [ST_W-1:0] r_state;
  logic [ST_W-1:0] w_state_nxt;
  logic            w_mul_start;

  assign w_is_mul = (op == OP_MUL);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state: leave IDLE only on an accepted MUL, return when product is ready
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept && w_is_mul) w_state_nxt = ST_MUL_BUSY;
      ST_MUL_BUSY: if (w_mul_done)           w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs: block input for the whole multiply, including the result-load cycle
  always_comb begin
    w_in_busy   = (r_state == ST_MUL_BUSY);
    w_mul_start = (r_state == ST_IDLE) && w_accept && w_is_mul;
  end

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (w_mul_start),
    .i_a       (a),
    .i_b       (b),
    .o_busy    (w_mul_busy),
    .o_done    (w_mul_done),
    .o_product (w_mul_prod)
  );
`else
  assign w_is_mul   = 1'b0;
  assign w_in_busy  = 1'b0;
  assign w_mul_busy = 1'b0;
  assign w_mul_done = 1'b0;
  assign w_mul_prod = '0;
`endif

  assign in_ready   = rst_n && !w_in_busy && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Output register: load a new result, otherwise hold until the consumer takes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_flags     <= '0;
    end else if (w_accept && !w_is_mul) begin
      r_out_valid      <= 1'b1;
      r_result         <= w_alu_res;
      r_flags.zero     <= (w_alu_res == '0);
      r_flags.negative <= w_alu_res[MSB];
      r_flags.carry    <= w_alu_c;
      r_flags.overflow <= w_alu_v;
      r_flags.illegal  <= w_alu_ill;
    end else if (w_mul_done) begin
      r_out_valid      <= 1'b1;
      r_result         <= w_mul_prod[MSB:0];
      r_flags.zero     <= (w_mul_prod[MSB:0] == '0);
      r_flags.negative <= w_mul_prod[MSB];
      r_flags.carry    <= 1'b0;
      r_flags.overflow <= (w_mul_prod[2*WIDTH-1:WIDTH] != '0);
      r_flags.illegal  <= 1'b0;
    end else if (w_out_xfer) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky overflow: a delivered overflowing result beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             r_ovf_sticky <= 1'b0;
    else if (w_out_xfer && r_flags.overflow) r_ovf_sticky <= 1'b1;
    else if (clr_sticky)                    r_ovf_sticky <= 1'b0;
  end

  assign out_valid  = r_out_valid;
  assign result     = r_result;
  assign zero       = r_flags.zero;
  assign negative   = r_flags.negative;
  assign carry      = r_flags.carry;
  assign overflow   = r_flags.overflow;
  assign illegal    = r_flags.illegal;
  assign busy       = w_mul_busy;
  assign ovf_sticky = r_ovf_sticky;

endmodule
`default_nettype wire
